// File: rtl/tester_pkg.sv
// Shared definitions for the per-pin vector sequencer: vector word layout,
// format code width and sequencer state encodings.
package tester_pkg;

  localparam int FMT_W             = 2;
  localparam int VEC_D             = 0;
  localparam int VEC_FF_LO         = 1;
  localparam int VEC_FF_HI         = VEC_FF_LO + FMT_W - 1;
  localparam int VEC_RPT_LO        = VEC_FF_HI + 1;
  localparam int VEC_RPT_W_DEFAULT = 8;
  localparam int VEC_RPT_HI        = VEC_RPT_LO + VEC_RPT_W_DEFAULT - 1;
  localparam int VEC_LAST          = VEC_RPT_HI + 1;

  // Field positions that move with the repeat-count width.
  function automatic int vec_rpt_hi(input int rpt_w);
    return VEC_RPT_LO + rpt_w - 1;
  endfunction

  function automatic int vec_last_bit(input int rpt_w);
    return VEC_RPT_LO + rpt_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/vec_fifo.sv
// First-word-fall-through synchronous FIFO holding sequencer vectors.
// The head word is visible combinationally whenever empty is low.
module vec_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             wr_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             rd_ok_s, wr_ok_s, wr_commit_s;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; a pop in the same clock frees room for a write into a full FIFO.
  always_comb begin
    rd_ok_s     = rd_en && !empty;
    wr_ok_s     = wr_en && (!full || rd_ok_s);
    wr_commit_s = wr_ok_s && !flush;
    wr_drop     = wr_en && full && !rd_ok_s && !flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ok_s ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
      rd_ptr_d = rd_ok_s ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/vector_sequencer.sv
// Per-pin vector sequencer: steps through FIFO-queued vectors one tester
// cycle at a time and drives D/FF/EN into the pin formatter.
module vector_sequencer
  import tester_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int RPT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [7:0]       CYCLE_LENGTH,
  input  logic             WR_EN,
  input  logic [RPT_W+3:0] WR_DATA,
  output logic             FULL,
  output logic             EMPTY,
  output logic             D_OUT,
  output logic [1:0]       FF_OUT,
  output logic             EN_OUT,
  output logic             CYCLE_START,
  output logic             BUSY,
  output logic             DONE,
  output logic             UNDERRUN,
  output logic             OVERFLOW
);

  localparam int VW      = RPT_W + 4;
  localparam int RPT_HI  = vec_rpt_hi(RPT_W);
  localparam int LAST_BT = vec_last_bit(RPT_W);

  seq_state_e       state_q, state_d;
  logic             d_q, d_d;
  logic [FMT_W-1:0] ff_q, ff_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             last_q, last_d;
  logic [7:0]       cyc_len_q, cyc_len_d;
  logic [7:0]       cyc_cnt_q, cyc_cnt_d;
  logic             en_q, en_d;
  logic             cyc_start_q, cyc_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic             overflow_q, overflow_d;

  logic [VW-1:0]    head_s;
  logic             fifo_empty_s, fifo_full_s, fifo_drop_s;
  logic             pop_s, flush_s, load_s;

  vec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (VW)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (WR_EN),
    .wr_data (WR_DATA),
    .rd_en   (pop_s),
    .flush   (flush_s),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .wr_drop (fifo_drop_s)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    ff_d        = ff_q;
    rpt_d       = rpt_q;
    last_d      = last_q;
    cyc_len_d   = cyc_len_q;
    cyc_cnt_d   = cyc_cnt_q;
    done_d      = 1'b0;
    underrun_d  = underrun_q;
    overflow_d  = overflow_q;
    flush_s     = 1'b0;
    load_s      = 1'b0;

    if (ABORT) begin
      state_d   = ST_IDLE;
      flush_s   = 1'b1;
      d_d       = 1'b0;
      ff_d      = '0;
      rpt_d     = '0;
      last_d    = 1'b0;
      cyc_cnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (START && !fifo_empty_s) begin
            load_s     = 1'b1;
            state_d    = ST_RUN;
            cyc_len_d  = (CYCLE_LENGTH == 8'd0) ? 8'd1 : CYCLE_LENGTH;
            cyc_cnt_d  = 8'd0;
            underrun_d = 1'b0;
            overflow_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          if (cyc_cnt_q == (cyc_len_q - 8'd1)) begin
            cyc_cnt_d = 8'd0;
            if (rpt_q != '0) begin
              rpt_d = rpt_q - RPT_W'(1);
            end else if (last_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (!fifo_empty_s) begin
              load_s = 1'b1;
            end else begin
              underrun_d = 1'b1;
              state_d    = ST_HALT;
            end
          end else begin
            cyc_cnt_d = cyc_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    pop_s = load_s;
    if (load_s) begin
      d_d    = head_s[VEC_D];
      ff_d   = head_s[VEC_FF_HI:VEC_FF_LO];
      rpt_d  = head_s[RPT_HI:VEC_RPT_LO];
      last_d = head_s[LAST_BT];
    end else begin
      last_d = last_d;
    end

    // A dropped write wins over the clear from an accepted START.
    overflow_d = overflow_d | fifo_drop_s;

    if (state_d == ST_RUN) begin
      en_d        = 1'b1;
      busy_d      = 1'b1;
      cyc_start_d = (cyc_cnt_d == 8'd0);
    end else begin
      en_d        = 1'b0;
      busy_d      = 1'b0;
      cyc_start_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      d_q         <= 1'b0;
      ff_q        <= '0;
      rpt_q       <= '0;
      last_q      <= 1'b0;
      cyc_len_q   <= 8'd1;
      cyc_cnt_q   <= 8'd0;
      en_q        <= 1'b0;
      cyc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      ff_q        <= ff_d;
      rpt_q       <= rpt_d;
      last_q      <= last_d;
      cyc_len_q   <= cyc_len_d;
      cyc_cnt_q   <= cyc_cnt_d;
      en_q        <= en_d;
      cyc_start_q <= cyc_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
    end
  end

  assign FULL        = fifo_full_s;
  assign EMPTY       = fifo_empty_s;
  assign D_OUT       = d_q;
  assign FF_OUT      = ff_q;
  assign EN_OUT      = en_q;
  assign CYCLE_START = cyc_start_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign UNDERRUN    = underrun_q;
  assign OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: a per-clock vector table plus
// hand-written multi-cycle sequences with hand-computed expectations.
module tb_vector_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, ABORT, WR_EN;
  logic [7:0]  CYCLE_LENGTH;
  logic [11:0] WR_DATA;
  logic        FULL, EMPTY, D_OUT, EN_OUT, CYCLE_START, BUSY, DONE, UNDERRUN, OVERFLOW;
  logic [1:0]  FF_OUT;

  int n_tests = 0;
  int n_fail  = 0;

  logic       tr_en [200];
  logic       tr_cs [200];
  logic       tr_dn [200];
  logic       tr_d  [200];
  logic [1:0] tr_ff [200];

  always #5 CLK = ~CLK;

  vector_sequencer #(.DEPTH(16), .RPT_W(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .CYCLE_LENGTH(CYCLE_LENGTH),
    .WR_EN(WR_EN), .WR_DATA(WR_DATA), .FULL(FULL), .EMPTY(EMPTY), .D_OUT(D_OUT),
    .FF_OUT(FF_OUT), .EN_OUT(EN_OUT), .CYCLE_START(CYCLE_START), .BUSY(BUSY),
    .DONE(DONE), .UNDERRUN(UNDERRUN), .OVERFLOW(OVERFLOW)
  );

  // Observed output bundle {FULL,EMPTY,D,FF,EN,CS,BUSY,DONE,UNDERRUN,OVERFLOW}.
  wire [10:0] obs = {FULL, EMPTY, D_OUT, FF_OUT, EN_OUT, CYCLE_START, BUSY, DONE, UNDERRUN, OVERFLOW};

  function automatic logic [10:0] mk(input logic f, input logic e, input logic d, input logic [1:0] ff,
                                     input logic en, input logic cs, input logic b, input logic dn,
                                     input logic u, input logic o);
    return {f, e, d, ff, en, cs, b, dn, u, o};
  endfunction

  typedef struct {
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  cl;
    logic        wr;
    logic [11:0] wd;
    logic [10:0] exp;
  } step_t;

  step_t tbl [14];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0; START = 1'b0; ABORT = 1'b0; WR_EN = 1'b0; WR_DATA = 12'h000; CYCLE_LENGTH = 8'd0;
    repeat (3) tick();
    RST = 1'b1;
  endtask

  task automatic write_vec(input logic [11:0] w);
    WR_EN = 1'b1; WR_DATA = w;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic start_seq(input logic [7:0] cl);
    CYCLE_LENGTH = cl; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      tr_en[k] = EN_OUT; tr_cs[k] = CYCLE_START; tr_dn[k] = DONE;
      tr_d[k]  = D_OUT;  tr_ff[k] = FF_OUT;
      tick();
    end
  endtask

  function automatic int cnt_en(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(tr_en[k]);
    return c;
  endfunction

  function automatic int cnt_cs(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(tr_cs[k]);
    return c;
  endfunction

  function automatic int cnt_dn(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(tr_dn[k]);
    return c;
  endfunction

  function automatic int first_dn(input int n);
    for (int k = 0; k < n; k++) if (tr_dn[k]) return k;
    return -1;
  endfunction

  initial begin
    int bad;
    int k;
    logic [3:0]  iv;
    logic [11:0] w;
    logic        exp_d  [200];
    logic [1:0]  exp_ff [200];

    RST = 1'b0; START = 1'b0; ABORT = 1'b0; WR_EN = 1'b0; WR_DATA = 12'h000; CYCLE_LENGTH = 8'd0;

    // Reset with writes held high, then a two-vector run at CYCLE_LENGTH=2.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 12'h123, mk(0,1,0,2'd0,0,0,0,0,0,0)};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 12'h456, mk(0,1,0,2'd0,0,0,0,0,0,0)};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 12'h789, mk(0,1,0,2'd0,0,0,0,0,0,0)};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 12'h003, mk(0,0,0,2'd0,0,0,0,0,0,0)};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 12'h80C, mk(0,0,0,2'd0,0,0,0,0,0,0)};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 12'h000, mk(0,0,1,2'd1,1,1,1,0,0,0)};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 12'h000, mk(0,0,1,2'd1,1,0,1,0,0,0)};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 12'h000, mk(0,1,0,2'd2,1,1,1,0,0,0)};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 12'h000, mk(0,1,0,2'd2,1,0,1,0,0,0)};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 12'h000, mk(0,1,0,2'd2,1,1,1,0,0,0)};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 12'h000, mk(0,1,0,2'd2,1,0,1,0,0,0)};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 12'h000, mk(0,1,0,2'd2,0,0,0,1,0,0)};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 12'h000, mk(0,1,0,2'd2,0,0,0,0,0,0)};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 12'h000, mk(0,1,0,2'd2,0,0,0,0,0,0)};

    for (int i = 0; i < 14; i++) begin
      RST = tbl[i].rst; START = tbl[i].start; ABORT = tbl[i].abort;
      CYCLE_LENGTH = tbl[i].cl; WR_EN = tbl[i].wr; WR_DATA = tbl[i].wd;
      tick();
      chk($sformatf("table_step%0d", i), 32'(obs), 32'(tbl[i].exp));
    end
    START = 1'b0; WR_EN = 1'b0;

    // Basic run: 15-clock cycles; CYCLE_LENGTH change after START must not matter.
    do_reset();
    write_vec(12'h003);
    write_vec(12'h804);
    start_seq(8'd15);
    CYCLE_LENGTH = 8'd3;
    capture(40);
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (j < 15 && !(tr_en[j] && tr_d[j] == 1'b1 && tr_ff[j] == 2'd1)) bad++;
      if (j >= 15 && j < 30 && !(tr_en[j] && tr_d[j] == 1'b0 && tr_ff[j] == 2'd2)) bad++;
      if (j >= 30 && tr_en[j]) bad++;
      if (tr_cs[j] != (j == 0 || j == 15)) bad++;
    end
    chk("basic_pattern", bad, 0);
    chk("basic_en_clocks", cnt_en(40), 30);
    chk("basic_done_at", first_dn(40), 30);
    chk("basic_done_count", cnt_dn(40), 1);

    // Repeat: REPEAT=3 at CYCLE_LENGTH=5 gives four tester cycles.
    write_vec(12'h81F);
    start_seq(8'd5);
    capture(30);
    chk("rpt_en_clocks", cnt_en(30), 20);
    chk("rpt_cs_count", cnt_cs(30), 4);
    chk("rpt_done_at", first_dn(30), 20);

    // Underrun on a non-LAST vector, then resume with a LAST vector.
    write_vec(12'h001);
    start_seq(8'd4);
    capture(6);
    chk("und_en_clocks", cnt_en(6), 4);
    chk("und_halt_state", 32'(obs), 32'(mk(0,1,1,2'd0,0,0,0,0,1,0)));
    write_vec(12'h806);
    start_seq(8'd4);
    chk("und_resume_clear", 32'(obs), 32'(mk(0,1,0,2'd3,1,1,1,0,0,0)));
    capture(8);
    chk("und_resume_done", first_dn(8), 4);

    // A write landing on the boundary of an empty FIFO is not visible in time.
    write_vec(12'h001);
    start_seq(8'd3);
    tick();
    tick();
    WR_EN = 1'b1; WR_DATA = 12'h801;
    tick();
    WR_EN = 1'b0;
    chk("und_same_clock_write", 32'(obs), 32'(mk(0,0,1,2'd0,0,0,0,0,1,0)));

    // Overflow and pointer wrap: move pointers off zero first.
    do_reset();
    for (int j = 0; j < 4; j++) write_vec(12'h000);
    write_vec(12'h800);
    start_seq(8'd1);
    repeat (8) tick();
    for (int j = 0; j < 16; j++) begin
      iv = 4'(j);
      w = 12'h000;
      w[0] = iv[0];
      w[2:1] = iv[2:1];
      w[3] = iv[3];
      w[11] = (j == 15);
      write_vec(w);
    end
    chk("ovf_full_after_16", 32'(obs), 32'(mk(1,0,0,2'd0,0,0,0,0,0,0)));
    write_vec(12'h7FF);
    chk("ovf_flag_set", 32'(obs), 32'(mk(1,0,0,2'd0,0,0,0,0,0,1)));
    start_seq(8'd1);
    chk("ovf_cleared_by_start", OVERFLOW, 1'b0);
    capture(30);
    k = 0;
    for (int j = 0; j < 16; j++) begin
      iv = 4'(j);
      for (int r = 0; r <= int'(iv[3]); r++) begin
        exp_d[k] = iv[0]; exp_ff[k] = iv[2:1]; k++;
      end
    end
    bad = 0;
    for (int j = 0; j < 30; j++) begin
      if (j < k && !(tr_en[j] && tr_cs[j] && tr_d[j] == exp_d[j] && tr_ff[j] == exp_ff[j])) bad++;
      if (j >= k && tr_en[j]) bad++;
    end
    chk("wrap_order", bad, 0);
    chk("wrap_done_at", first_dn(30), 24);
    chk("wrap_empty_after", EMPTY, 1'b1);

    // ABORT mid-run flushes and suppresses DONE.
    do_reset();
    write_vec(12'h003);
    write_vec(12'h003);
    write_vec(12'h805);
    start_seq(8'd4);
    tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_idle", 32'(obs), 32'(mk(0,1,0,2'd0,0,0,0,0,0,0)));
    capture(10);
    chk("abort_no_done", cnt_dn(10) + cnt_en(10), 0);

    // ABORT beats START in the same clock.
    write_vec(12'h801);
    CYCLE_LENGTH = 8'd4; START = 1'b1; ABORT = 1'b1;
    tick();
    START = 1'b0; ABORT = 1'b0;
    chk("abort_beats_start", 32'(obs), 32'(mk(0,1,0,2'd0,0,0,0,0,0,0)));

    // CYCLE_LENGTH=0 behaves as one clock per tester cycle.
    write_vec(12'h81F);
    start_seq(8'd0);
    capture(8);
    chk("cl0_cs_count", cnt_cs(8), 4);
    chk("cl0_en_clocks", cnt_en(8), 4);
    chk("cl0_done_at", first_dn(8), 4);

    // Mid-run reset returns everything to the reset state.
    write_vec(12'h803);
    write_vec(12'h803);
    start_seq(8'd4);
    tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("midrun_reset", 32'(obs), 32'(mk(0,1,0,2'd0,0,0,0,0,0,0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
